// File: rtl/gcn_pkg.sv
// Shared parameters, FSM state encoding and element/accumulator types for the GCN engine.
package gcn_pkg;
  localparam int FEATURE_ROWS      = 6;
  localparam int FEATURE_COLS      = 96;
  localparam int WEIGHT_ROWS       = 96;
  localparam int WEIGHT_COLS       = 3;
  localparam int FEATURE_WIDTH     = 5;
  localparam int WEIGHT_WIDTH      = 5;
  localparam int DOT_PROD_WIDTH    = 16;
  localparam int ADDRESS_WIDTH     = 13;
  localparam int COO_NUM_OF_COLS   = 6;
  localparam int COO_BW            = $clog2(COO_NUM_OF_COLS);
  localparam int MAX_ADDRESS_WIDTH = 2;
  localparam int WCOL_BW           = $clog2(WEIGHT_COLS);

  localparam logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = 13'h200;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_COMB, S_AGG, S_ARGMAX, S_DONE} state_t;

  typedef logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0]   wvec_t;
  typedef logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0] fvec_t;
  typedef logic [DOT_PROD_WIDTH-1:0]                  acc_t;
  typedef acc_t [WEIGHT_COLS-1:0]                     acc_row_t;
  typedef logic [MAX_ADDRESS_WIDTH-1:0]               cls_t;

  // Strict compare keeps the lowest index on ties.
  function automatic cls_t argmax_row(input acc_row_t v);
    cls_t idx;
    acc_t best;
    idx  = '0;
    best = v[0];
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (v[c] > best) begin
        best = v[c];
        idx  = cls_t'(c);
      end
    end
    return idx;
  endfunction
endpackage

// File: rtl/gcn_dot_product.sv
// Combinational 96-term unsigned dot product, wrapping modulo 2^DOT_PROD_WIDTH.
module gcn_dot_product
  import gcn_pkg::*;
(
  input  fvec_t i_f,
  input  wvec_t i_w,
  output acc_t  o_dot
);
  always_comb begin
    o_dot = '0;
    for (int k = 0; k < FEATURE_COLS; k++)
      o_dot = o_dot + acc_t'(i_f[k]) * acc_t'(i_w[k]);
  end
endmodule

// File: rtl/gcn.sv
// Single-layer GCN inference: load weights, FM*WM, COO neighbour aggregation, per-node argmax.
// Define GCN_SELF_LOOP_EN to add each node's own FMWM row before the argmax.
module gcn
  import gcn_pkg::*;
(
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  wvec_t                                          data_in,
  input  logic [2*COO_BW-1:0]                            coo_in,
  output logic [COO_BW-1:0]                              coo_address,
  output logic [ADDRESS_WIDTH-1:0]                       read_address,
  output logic                                           enable_read,
  output logic                                           done,
  output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] max_addi_answer
);
  state_t                            r_state;
  logic [COO_BW-1:0]                 r_cnt;
  wvec_t [WEIGHT_COLS-1:0]           r_w;
  acc_row_t [FEATURE_ROWS-1:0]       r_fmwm;
  acc_row_t [FEATURE_ROWS-1:0]       r_agg;

  acc_row_t                          w_dot;
  acc_row_t [FEATURE_ROWS-1:0]       w_agg_nxt;
  acc_row_t                          w_srow, w_drow;
  logic [COO_BW-1:0]                 w_src, w_dst;
  logic                              w_edge_ok;
  logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] w_ans;

  // One MAC tree per class; the feature row arrives on data_in during COMB.
  for (genvar c = 0; c < WEIGHT_COLS; c++) begin : g_dot
    gcn_dot_product u_dot (.i_f(data_in), .i_w(r_w[c]), .o_dot(w_dot[c]));
  end

  assign w_src     = coo_in[2*COO_BW-1:COO_BW];
  assign w_dst     = coo_in[COO_BW-1:0];
  assign w_edge_ok = (w_src != '0) && (w_dst != '0) &&
                     (w_src <= COO_BW'(FEATURE_ROWS)) && (w_dst <= COO_BW'(FEATURE_ROWS));

  // Node ids are 1-based; a self edge hits both adds on the same row.
  always_comb begin
    w_srow = '0;
    w_drow = '0;
    for (int j = 0; j < FEATURE_ROWS; j++) begin
      if (w_src == COO_BW'(j+1)) w_srow = r_fmwm[j];
      if (w_dst == COO_BW'(j+1)) w_drow = r_fmwm[j];
    end
    w_agg_nxt = r_agg;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      for (int c = 0; c < WEIGHT_COLS; c++) begin
        if (w_edge_ok && w_src == COO_BW'(r+1)) w_agg_nxt[r][c] = w_agg_nxt[r][c] + w_drow[c];
        if (w_edge_ok && w_dst == COO_BW'(r+1)) w_agg_nxt[r][c] = w_agg_nxt[r][c] + w_srow[c];
      end
    end
  end

  always_comb begin
    acc_row_t s;
    s     = '0;
    w_ans = '0;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      for (int c = 0; c < WEIGHT_COLS; c++) begin
`ifdef GCN_SELF_LOOP_EN
        s[c] = r_agg[r][c] + r_fmwm[r][c];
`else
        s[c] = r_agg[r][c];
`endif
      end
      w_ans[r] = argmax_row(s);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_w             <= '0;
      r_fmwm          <= '0;
      r_agg           <= '0;
      coo_address     <= '0;
      read_address    <= '0;
      enable_read     <= 1'b0;
      done            <= 1'b0;
      max_addi_answer <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state      <= S_LOAD_W;
          r_cnt        <= '0;
          r_agg        <= '0;
          read_address <= '0;
          enable_read  <= 1'b1;
        end
        S_LOAD_W: begin
          r_w[r_cnt[WCOL_BW-1:0]] <= data_in;
          if (r_cnt == COO_BW'(WEIGHT_COLS-1)) begin
            r_state      <= S_COMB;
            r_cnt        <= '0;
            read_address <= FEATURE_BASE;
          end else begin
            r_cnt        <= r_cnt + COO_BW'(1);
            read_address <= read_address + ADDRESS_WIDTH'(1);
          end
        end
        S_COMB: begin
          r_fmwm[r_cnt] <= w_dot;
          if (r_cnt == COO_BW'(FEATURE_ROWS-1)) begin
            r_state      <= S_AGG;
            r_cnt        <= '0;
            read_address <= '0;
            enable_read  <= 1'b0;
            coo_address  <= '0;
          end else begin
            r_cnt        <= r_cnt + COO_BW'(1);
            read_address <= read_address + ADDRESS_WIDTH'(1);
          end
        end
        S_AGG: begin
          r_agg <= w_agg_nxt;
          if (r_cnt == COO_BW'(COO_NUM_OF_COLS-1)) begin
            r_state     <= S_ARGMAX;
            r_cnt       <= '0;
            coo_address <= '0;
          end else begin
            r_cnt       <= r_cnt + COO_BW'(1);
            coo_address <= coo_address + COO_BW'(1);
          end
        end
        S_ARGMAX: begin
          max_addi_answer <= w_ans;
          done            <= 1'b1;
          r_state         <= S_DONE;
        end
        default: r_state <= S_DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcn.sv
// Self-checking bench for gcn: vector table + reference model + answer scoreboard.
module tb_gcn;
  import gcn_pkg::*;
  typedef logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] ans_t;

  logic                     clk = 1'b0;
  logic                     reset, start;
  wvec_t                    data_in;
  logic [2*COO_BW-1:0]      coo_in;
  logic [COO_BW-1:0]        coo_address;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic                     enable_read, done;
  ans_t                     max_addi_answer;

  always #5 clk = ~clk;

  gcn dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .coo_in(coo_in),
    .coo_address(coo_address), .read_address(read_address), .enable_read(enable_read),
    .done(done), .max_addi_answer(max_addi_answer)
  );

  wvec_t               tw   [WEIGHT_COLS];
  fvec_t               tf   [FEATURE_ROWS];
  logic [2*COO_BW-1:0] tcoo [COO_NUM_OF_COLS];

  int   n_chk  = 0;
  int   n_fail = 0;
  ans_t sb_q[$];

  // Memory model: combinational read of the addressed word.
  always_comb begin
    data_in = '0;
    coo_in  = '0;
    if (read_address < ADDRESS_WIDTH'(WEIGHT_COLS))
      data_in = tw[read_address[1:0]];
    else if (read_address >= FEATURE_BASE && read_address < FEATURE_BASE + ADDRESS_WIDTH'(FEATURE_ROWS))
      data_in = tf[read_address[2:0]];
    if (coo_address < COO_BW'(COO_NUM_OF_COLS))
      coo_in = tcoo[coo_address];
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2*COO_BW-1:0] edg(input int s, input int d);
    return {COO_BW'(s), COO_BW'(d)};
  endfunction

  task automatic load(input int wm, input int fm, input int em);
    for (int c = 0; c < WEIGHT_COLS; c++)
      for (int k = 0; k < WEIGHT_ROWS; k++)
        case (wm)
          0:       tw[c][k] = 5'd0;
          1:       tw[c][k] = (c == 2) ? 5'd1 : 5'd0;
          2:       tw[c][k] = 5'd31;
          default: tw[c][k] = 5'($urandom_range(0, 31));
        endcase
    for (int r = 0; r < FEATURE_ROWS; r++)
      for (int k = 0; k < FEATURE_COLS; k++)
        case (fm)
          0:       tf[r][k] = 5'd1;
          1:       tf[r][k] = 5'd31;
          default: tf[r][k] = 5'($urandom_range(0, 31));
        endcase
    for (int e = 0; e < COO_NUM_OF_COLS; e++)
      case (em)
        0: tcoo[e] = edg(e + 1, (e + 1) % 6 + 1);
        1: tcoo[e] = edg(1, 2);
        2: case (e)
             0: tcoo[e] = edg(0, 3);
             1: tcoo[e] = edg(7, 1);
             2: tcoo[e] = edg(3, 0);
             3: tcoo[e] = edg(0, 0);
             4: tcoo[e] = edg(7, 7);
             default: tcoo[e] = edg(2, 7);
           endcase
        default: tcoo[e] = edg($urandom_range(0, 7), $urandom_range(0, 7));
      endcase
  endtask

  function automatic ans_t model();
    int fm [FEATURE_ROWS][WEIGHT_COLS];
    int ag [FEATURE_ROWS][WEIGHT_COLS];
    int s, d, bi, best, sc;
    ans_t a;
    a = '0;
    for (int r = 0; r < FEATURE_ROWS; r++)
      for (int c = 0; c < WEIGHT_COLS; c++) begin
        fm[r][c] = 0;
        ag[r][c] = 0;
        for (int k = 0; k < FEATURE_COLS; k++)
          fm[r][c] += int'(tf[r][k]) * int'(tw[c][k]);
        fm[r][c] = fm[r][c] % 65536;
      end
    for (int e = 0; e < COO_NUM_OF_COLS; e++) begin
      s = int'(tcoo[e][5:3]);
      d = int'(tcoo[e][2:0]);
      if (s >= 1 && s <= 6 && d >= 1 && d <= 6)
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          ag[s-1][c] = (ag[s-1][c] + fm[d-1][c]) % 65536;
          ag[d-1][c] = (ag[d-1][c] + fm[s-1][c]) % 65536;
        end
    end
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      bi = 0;
      best = -1;
      for (int c = 0; c < WEIGHT_COLS; c++) begin
`ifdef GCN_SELF_LOOP_EN
        sc = (ag[r][c] + fm[r][c]) % 65536;
`else
        sc = ag[r][c];
`endif
        if (sc > best) begin best = sc; bi = c; end
      end
      a[r] = 2'(bi);
    end
    return a;
  endfunction

  task automatic run_case(input string name, input ans_t exp);
    int   k, en_cnt;
    bit   seen;
    ans_t want;
    sb_q.push_back(exp);
    @(negedge clk) start = 1'b1;
    k = 0; en_cnt = 0; seen = 0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      start = 1'b0;
      if (enable_read) en_cnt++;
      if (done) seen = 1;
    end
    check({name, " latency"}, k, 17);
    check({name, " enable_read cycles"}, en_cnt, 9);
    if (sb_q.size() > 0) begin
      want = sb_q.pop_front();
      for (int r = 0; r < FEATURE_ROWS; r++)
        check($sformatf("%s node%0d", name, r + 1), int'(max_addi_answer[r]), int'(want[r]));
    end
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 check({name, " done sticky"}, int'(done), 1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    #1;
    check("reset done", int'(done), 0);
    check("reset answers", int'(max_addi_answer), 0);
    @(negedge clk) reset = 1'b1;
  endtask

  typedef struct {
    int   wm, fm, em;
    bit   use_model;
    ans_t exp;
  } vec_s;

`ifdef GCN_SELF_LOOP_EN
  localparam ans_t E_PAIR = 12'haaa;
  localparam ans_t E_OOR  = 12'haaa;
  localparam ans_t E_SELF = 12'haaa;
`else
  localparam ans_t E_PAIR = 12'h00a;
  localparam ans_t E_OOR  = 12'h000;
  localparam ans_t E_SELF = 12'h002;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_s vt[8];
    ans_t e;
    vt[0] = '{1, 0, 0, 0, 12'haaa};
    vt[1] = '{1, 0, 1, 0, E_PAIR};
    vt[2] = '{0, 0, 0, 0, 12'h000};
    vt[3] = '{2, 1, 0, 0, 12'h000};
    vt[4] = '{1, 0, 2, 0, E_OOR};
    vt[5] = '{3, 2, 3, 1, 12'h000};
    vt[6] = '{3, 2, 3, 1, 12'h000};
    vt[7] = '{3, 2, 0, 1, 12'h000};

    // Reset held with start high: nothing moves.
    load(1, 0, 0);
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle done", int'(done), 0);
    check("idle enable_read", int'(enable_read), 0);
    check("idle answers", int'(max_addi_answer), 0);
    @(negedge clk) begin reset = 1'b1; start = 1'b0; end

    for (int i = 0; i < 8; i++) begin
      load(vt[i].wm, vt[i].fm, vt[i].em);
      e = vt[i].use_model ? model() : vt[i].exp;
      run_case($sformatf("vec%0d", i), e);
      if (vt[i].wm == 2)
        check("fmwm wrap", int'(dut.r_fmwm[0][0]), 26720);
      do_reset();
    end

    // Self edge 1-1 adds node 1's row twice.
    load(1, 0, 2);
    tcoo[0] = edg(1, 1);
    for (int j = 1; j < COO_NUM_OF_COLS; j++) tcoo[j] = edg(0, 0);
    run_case("self_edge", E_SELF);
    check("self_edge agg", int'(dut.r_agg[0][2]), 192);
    do_reset();

    // Abort during COMB, then restart.
    load(1, 0, 0);
    @(negedge clk) start = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk) begin start = 1'b0; reset = 1'b0; end
    #1;
    check("abort done", int'(done), 0);
    check("abort enable_read", int'(enable_read), 0);
    @(negedge clk) reset = 1'b1;
    run_case("restart", 12'haaa);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
